// File: rtl/box_drawer_if.sv
// Request channel from a location processor to its box drawer.
interface box_drawer_if;
  logic       m_valid;
  logic       m_ready;
  logic [8:0] box_x;
  logic [8:0] box_y;
  logic [2:0] in_color;

  modport master (output m_valid, box_x, box_y, in_color, input m_ready);
  modport slave  (input m_valid, box_x, box_y, in_color, output m_ready);
endinterface

// File: rtl/box_drawer.sv
// Box drawer: on each accepted request, erases the previously drawn box with the
// background colour and then draws the new box, one pixel per clock, raster order.
//
//  state   | meaning
//  S_IDLE  | ready for a request, no pixel output
//  S_ERASE | scanning the previous box in BG_COLOR
//  S_DRAW  | scanning the new box in the requested colour
module box_drawer #(
  parameter logic [8:0] BOX_WIDTH     = 9'd10,
  parameter logic [8:0] BOX_HEIGHT    = 9'd48,
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240,
  parameter logic [2:0] BG_COLOR      = 3'b000
) (
  input  logic         clock,
  input  logic         reset_n,
  box_drawer_if.slave  s_req,
  output logic [8:0]   o_vga_x,
  output logic [8:0]   o_vga_y,
  output logic [2:0]   o_vga_colour,
  output logic         o_vga_plot,
  output logic         o_done
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;

  state_t     r_state, w_state_nxt;
  logic [8:0] r_cx, w_cx_nxt;
  logic [8:0] r_cy, w_cy_nxt;
  logic [8:0] r_cur_x, w_cur_x_nxt;
  logic [8:0] r_cur_y, w_cur_y_nxt;
  logic [2:0] r_cur_col, w_cur_col_nxt;
  logic [8:0] r_prev_x, w_prev_x_nxt;
  logic [8:0] r_prev_y, w_prev_y_nxt;
  logic       r_has_prev, w_has_prev_nxt;
  logic       r_done, w_done_nxt;

  logic       w_row_end;
  logic       w_last;
  logic [8:0] w_base_x;
  logic [8:0] w_base_y;
  logic [9:0] w_sum_x;
  logic [9:0] w_sum_y;

  assign w_row_end = (r_cx == BOX_WIDTH - 9'd1);
  assign w_last    = w_row_end && (r_cy == BOX_HEIGHT - 9'd1);

  // Ready depends on state only so the requester never sees a combinational loop.
  assign s_req.m_ready = (r_state == S_IDLE);
  assign o_done        = r_done;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cx       <= 9'd0;
      r_cy       <= 9'd0;
      r_cur_x    <= 9'd0;
      r_cur_y    <= 9'd0;
      r_cur_col  <= 3'd0;
      r_prev_x   <= 9'd0;
      r_prev_y   <= 9'd0;
      r_has_prev <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cx       <= w_cx_nxt;
      r_cy       <= w_cy_nxt;
      r_cur_x    <= w_cur_x_nxt;
      r_cur_y    <= w_cur_y_nxt;
      r_cur_col  <= w_cur_col_nxt;
      r_prev_x   <= w_prev_x_nxt;
      r_prev_y   <= w_prev_y_nxt;
      r_has_prev <= w_has_prev_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic: accept in idle, raster-scan erase then draw.
  always_comb begin
    w_state_nxt    = r_state;
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;
    w_cur_x_nxt    = r_cur_x;
    w_cur_y_nxt    = r_cur_y;
    w_cur_col_nxt  = r_cur_col;
    w_prev_x_nxt   = r_prev_x;
    w_prev_y_nxt   = r_prev_y;
    w_has_prev_nxt = r_has_prev;
    w_done_nxt     = 1'b0;

    if (r_state != S_IDLE) begin
      if (w_row_end) begin
        w_cx_nxt = 9'd0;
        w_cy_nxt = r_cy + 9'd1;
      end else begin
        w_cx_nxt = r_cx + 9'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (s_req.m_valid) begin
          w_cur_x_nxt   = s_req.box_x;
          w_cur_y_nxt   = s_req.box_y;
          w_cur_col_nxt = s_req.in_color;
          w_cx_nxt      = 9'd0;
          w_cy_nxt      = 9'd0;
          w_state_nxt   = r_has_prev ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE: begin
        if (w_last) begin
          w_cx_nxt    = 9'd0;
          w_cy_nxt    = 9'd0;
          w_state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        if (w_last) begin
          w_cx_nxt       = 9'd0;
          w_cy_nxt       = 9'd0;
          w_prev_x_nxt   = r_cur_x;
          w_prev_y_nxt   = r_cur_y;
          w_has_prev_nxt = 1'b1;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel output: sums kept 10 bits wide so off-screen pixels never wrap on-screen.
  always_comb begin
    w_base_x     = (r_state == S_ERASE) ? r_prev_x : r_cur_x;
    w_base_y     = (r_state == S_ERASE) ? r_prev_y : r_cur_y;
    w_sum_x      = {1'b0, w_base_x} + {1'b0, r_cx};
    w_sum_y      = {1'b0, w_base_y} + {1'b0, r_cy};
    o_vga_x      = 9'd0;
    o_vga_y      = 9'd0;
    o_vga_colour = BG_COLOR;
    o_vga_plot   = 1'b0;
    if (r_state != S_IDLE) begin
      o_vga_x      = w_sum_x[8:0];
      o_vga_y      = w_sum_y[8:0];
      o_vga_colour = (r_state == S_DRAW) ? r_cur_col : BG_COLOR;
      o_vga_plot   = (w_sum_x < {1'b0, SCREEN_WIDTH}) && (w_sum_y < {1'b0, SCREEN_HEIGHT});
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// Self-checking bench for box_drawer with a 4x3 box on a 320x240 screen.
module tb_box_drawer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int SW = 320;
  localparam int SH = 240;

  logic       clock;
  logic       reset_n;
  logic [8:0] vga_x;
  logic [8:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;

  int total = 0;
  int bad   = 0;

  box_drawer_if bif();

  box_drawer #(
    .BOX_WIDTH(9'd4), .BOX_HEIGHT(9'd3),
    .SCREEN_WIDTH(9'd320), .SCREEN_HEIGHT(9'd240), .BG_COLOR(3'b000)
  ) dut (
    .clock(clock), .reset_n(reset_n), .s_req(bif.slave),
    .o_vga_x(vga_x), .o_vga_y(vga_y), .o_vga_colour(vga_colour),
    .o_vga_plot(vga_plot), .o_done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request expands into a list of expected
  // per-cycle pixels (erase of the previous box, then the new box).
  typedef struct {
    logic       plot;
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] col;
  } pix_t;

  pix_t q[$];
  bit   m_has_prev = 0;
  int   m_prev_x = 0;
  int   m_prev_y = 0;
  bit   exp_done = 0;
  int   n_xfer = 0;

  task automatic push_box(input int bx, input int by, input logic [2:0] c);
    pix_t p;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        p.plot = ((bx + xx) < SW) && ((by + yy) < SH);
        p.x    = 9'((bx + xx) % 512);
        p.y    = 9'((by + yy) % 512);
        p.col  = c;
        q.push_back(p);
      end
  endtask

  // Cycle monitor: compares every cycle's outputs against the model.
  always @(negedge clock) begin
    bit   idle;
    pix_t r;
    idle = (q.size() == 0);
    chk("m_ready", int'(bif.m_ready), int'(idle));
    chk("done", int'(done), int'(exp_done));
    if (!idle) r = q.pop_front();
    else begin
      r.plot = 1'b0; r.x = 9'd0; r.y = 9'd0; r.col = 3'b000;
    end
    chk("vga_plot", int'(vga_plot), int'(r.plot));
    chk("vga_x", int'(vga_x), int'(r.x));
    chk("vga_y", int'(vga_y), int'(r.y));
    chk("vga_colour", int'(vga_colour), int'(r.col));
    exp_done = 0;
    if (!reset_n) begin
      q.delete();
      m_has_prev = 0;
    end else begin
      if (!idle && q.size() == 0) exp_done = 1;
      if (bif.m_valid && bif.m_ready) n_xfer++;
      if (idle && bif.m_valid) begin
        if (m_has_prev) push_box(m_prev_x, m_prev_y, 3'b000);
        push_box(int'(bif.box_x), int'(bif.box_y), bif.in_color);
        m_prev_x   = int'(bif.box_x);
        m_prev_y   = int'(bif.box_y);
        m_has_prev = 1;
      end
    end
  end

  task automatic wait_ready(input string nm);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!bif.m_ready && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    if (guard >= 200) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
  endtask

  // One request; returns after the done cycle. exp_busy < 0 skips length checks.
  task automatic do_txn(input string nm, input int x, input int y, input int c,
                        input int exp_busy, input int exp_plots);
    int busy, plots;
    @(posedge clock); #1;
    bif.m_valid = 1'b1; bif.box_x = 9'(x); bif.box_y = 9'(y); bif.in_color = 3'(c);
    wait_ready({nm, "_accept"});
    @(posedge clock); #1 bif.m_valid = 1'b0;
    busy = 0; plots = 0;
    @(negedge clock);
    while (!bif.m_ready && busy < 200) begin
      busy++;
      plots += int'(vga_plot);
      @(negedge clock);
    end
    if (busy >= 200) chk({nm, "_timeout"}, 1, 0);
    chk({nm, "_done"}, int'(done), 1);
    if (exp_busy >= 0) begin
      chk({nm, "_busy"}, busy, exp_busy);
      chk({nm, "_plots"}, plots, exp_plots);
    end
  endtask

  typedef struct {
    int x; int y; int col; int busy; int plots;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n0, idle_cnt, plots, guard;
    vecs[0] = '{x:10,  y:20,  col:4, busy:12, plots:12};
    vecs[1] = '{x:12,  y:20,  col:2, busy:24, plots:24};
    vecs[2] = '{x:318, y:238, col:7, busy:24, plots:16};
    vecs[3] = '{x:510, y:20,  col:3, busy:24, plots:4};
    vecs[4] = '{x:100, y:100, col:5, busy:24, plots:12};

    reset_n = 1'b0;
    bif.m_valid = 1'b0; bif.box_x = 9'd0; bif.box_y = 9'd0; bif.in_color = 3'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", int'(bif.m_ready), 1);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), 0);
    chk("rst_done", int'(done), 0);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].col,
             vecs[i].busy, vecs[i].plots);

    // Request held valid through busy with changed data: accepted once more only.
    n0 = n_xfer;
    @(posedge clock); #1;
    bif.m_valid = 1'b1; bif.box_x = 9'd50; bif.box_y = 9'd60; bif.in_color = 3'd1;
    wait_ready("hold_a");
    @(posedge clock); #1;
    bif.box_x = 9'd52; bif.box_y = 9'd61; bif.in_color = 3'd6;
    wait_ready("hold_b");
    @(posedge clock); #1 bif.m_valid = 1'b0;
    wait_ready("hold_end");
    chk("hold_xfers", n_xfer - n0, 2);

    // Idle with no request: nothing plotted.
    plots = 0;
    repeat (6) begin
      @(negedge clock);
      plots += int'(vga_plot) + int'(!bif.m_ready);
    end
    chk("idle_quiet", plots, 0);

    // Reset in the middle of a draw-only pass.
    pulse_reset();
    @(posedge clock); #1;
    bif.m_valid = 1'b1; bif.box_x = 9'd30; bif.box_y = 9'd40; bif.in_color = 3'd3;
    wait_ready("mid_accept");
    @(posedge clock); #1 bif.m_valid = 1'b0;
    repeat (5) @(negedge clock);
    pulse_reset();
    @(negedge clock);
    chk("mid_rst_ready", int'(bif.m_ready), 1);
    chk("mid_rst_plot", int'(vga_plot), 0);
    do_txn("after_rst_clip", 510, 5, 2, 12, 0);

    // Back-to-back requests with valid held high: one idle cycle between them.
    @(posedge clock); #1;
    bif.m_valid = 1'b1; bif.box_x = 9'd200; bif.box_y = 9'd100; bif.in_color = 3'd5;
    wait_ready("b2b_a");
    @(posedge clock); #1;
    bif.box_x = 9'd201; bif.box_y = 9'd102; bif.in_color = 3'd6;
    wait_ready("b2b_end_a");
    idle_cnt = 0; guard = 0;
    while (bif.m_ready && guard < 10) begin
      idle_cnt++; guard++;
      @(negedge clock);
    end
    @(posedge clock); #1 bif.m_valid = 1'b0;
    chk("b2b_idle_cycles", idle_cnt, 1);
    wait_ready("b2b_end_b");

    // Randomized requests, biased toward the screen edges.
    for (int i = 0; i < 30; i++) begin
      int rx, ry;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      rx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 511)) : int'($urandom_range(310, 325));
      ry = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 511)) : int'($urandom_range(230, 245));
      do_txn("rand", rx, ry, int'($urandom_range(0, 7)), -1, 0);
    end

    repeat (3) @(negedge clock);
    chk("model_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
